// File: rtl/enemy_lane_engine.sv
// enemy_lane_engine: N falling enemy cars, one per lane, each with its own
// parked/falling state and y position, plus a two-stage pixel path that
// turns the beam position into a sprite ROM address for the lowest-index
// lane under the beam and returns that lane's colour.
//
// Output qualifier: pixel_valid=1 marks the cycle's pixel as belonging to
// an enemy sprite (colour 000 included). There is no backpressure; a new
// beam sample enters every clock and leaves two clocks later.
module enemy_lane_engine #(
   parameter int N       = 4,
   parameter int SPR_W   = 80,
   parameter int SPR_H   = 121,
   parameter int ADDR_W  = 14,
   parameter int SPEED   = 1,
   parameter int Y_LIMIT = 601,
   parameter int Y_PARK  = 620,
   parameter int H_ACT   = 640,
   parameter int V_ACT   = 480
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tick,
   input  logic [N-1:0]      spawn,
   input  logic [N*10-1:0]   lane_x,
   input  logic              freeze,
   input  logic [9:0]        hcount,
   input  logic [9:0]        vcount,
   output logic [N*10-1:0]   pos_y,
   output logic [N-1:0]      active,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [2:0]        rom_data,
   output logic [2:0]        pixel,
   output logic              pixel_valid
);

   typedef enum logic {
      LANE_PARKED  = 1'b0,
      LANE_FALLING = 1'b1
   } lane_state_e;

   lane_state_e       state_q [N];
   lane_state_e       state_d [N];
   logic [9:0]        y_q     [N];
   logic [9:0]        y_d     [N];
   logic [10:0]       y_step  [N];
   logic [N-1:0]      lane_hit;
   logic [ADDR_W-1:0] lane_addr [N];

   logic              hit_d, hit_q;
   logic [ADDR_W-1:0] rom_addr_d, rom_addr_q;
   logic [2:0]        pixel_d, pixel_q;
   logic              pixel_valid_d, pixel_valid_q;

   // Per-lane geometry: all sums are 11 bits so x+SPR_W and y+SPR_H never wrap.
   for (genvar g = 0; g < N; g++) begin : g_lane
      logic [10:0] y_ext, x_ext, v_ext, h_ext, dy, dx;
      assign y_ext     = {1'b0, y_q[g]};
      assign x_ext     = {1'b0, lane_x[10*g +: 10]};
      assign v_ext     = {1'b0, vcount};
      assign h_ext     = {1'b0, hcount};
      assign y_step[g] = y_ext + 11'(SPEED);
      assign lane_hit[g] = (v_ext < 11'(V_ACT)) && (h_ext < 11'(H_ACT)) &&
                           (y_ext <= v_ext) && (v_ext < y_ext + 11'(SPR_H)) &&
                           (x_ext <= h_ext) && (h_ext < x_ext + 11'(SPR_W));
      assign dy = v_ext - y_ext;
      assign dx = h_ext - x_ext;
      // Address is recomputed from the beam every pixel, so nothing drifts.
      assign lane_addr[g] = ADDR_W'(32'(dy) * 32'(SPR_W) + 32'(dx));
   end

   // Lane state register: parked at Y_PARK out of reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N; i++) begin
            state_q[i] <= LANE_PARKED;
            y_q[i]     <= 10'(Y_PARK);
         end
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
      end
   end

   // Lane next state: only a non-frozen tick moves, spawns or parks a lane.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         state_d[i] = state_q[i];
         y_d[i]     = y_q[i];
         if (tick && !freeze) begin
            if (spawn[i]) begin
               state_d[i] = LANE_FALLING;
               y_d[i]     = '0;
            end else if (state_q[i] == LANE_FALLING) begin
               if (y_step[i] < 11'(Y_LIMIT)) begin
                  y_d[i] = y_step[i][9:0];
               end else begin
                  state_d[i] = LANE_PARKED;
                  y_d[i]     = 10'(Y_PARK);
               end
            end
         end
      end
   end

   // Lane outputs: packed y positions and the falling flags (the lane state).
   always_comb begin
      pos_y  = '0;
      active = '0;
      for (int i = 0; i < N; i++) begin
         pos_y[10*i +: 10] = y_q[i];
         active[i]         = (state_q[i] == LANE_FALLING);
      end
   end

   // Priority select: scan high to low so the lowest hitting lane wins.
   always_comb begin
      hit_d      = 1'b0;
      rom_addr_d = '0;
      for (int i = N-1; i >= 0; i--) begin
         if (lane_hit[i]) begin
            hit_d      = 1'b1;
            rom_addr_d = lane_addr[i];
         end
      end
   end

   // Stage-2 inputs: colour from the asynchronous ROM, hit flag from stage 1.
   always_comb begin
      pixel_d       = rom_data;
      pixel_valid_d = hit_q;
   end

   // Pixel pipeline registers: address/hit, then colour/valid.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rom_addr_q    <= '0;
         hit_q         <= 1'b0;
         pixel_q       <= '0;
         pixel_valid_q <= 1'b0;
      end else begin
         rom_addr_q    <= rom_addr_d;
         hit_q         <= hit_d;
         pixel_q       <= pixel_d;
         pixel_valid_q <= pixel_valid_d;
      end
   end

   assign rom_addr    = rom_addr_q;
   assign pixel       = pixel_q;
   assign pixel_valid = pixel_valid_q;

endmodule

// File: tb/tb_enemy_lane_engine.sv
// Testbench for enemy_lane_engine: directed scenarios plus a randomized
// stream checked against a lane/beam reference model kept here.
module tb_enemy_lane_engine;
   localparam int N       = 4;
   localparam int SPR_W   = 80;
   localparam int SPR_H   = 121;
   localparam int ADDR_W  = 14;
   localparam int SPEED   = 1;
   localparam int Y_LIMIT = 601;
   localparam int Y_PARK  = 620;
   localparam int H_ACT   = 640;
   localparam int V_ACT   = 480;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              tick = 1'b0;
   logic [N-1:0]      spawn = '0;
   logic [N*10-1:0]   lane_x = '0;
   logic              freeze = 1'b0;
   logic [9:0]        hcount = 10'd1000;
   logic [9:0]        vcount = 10'd1000;
   logic [N*10-1:0]   pos_y;
   logic [N-1:0]      active;
   logic [ADDR_W-1:0] rom_addr;
   logic [2:0]        rom_data;
   logic [2:0]        pixel;
   logic              pixel_valid;

   int checks = 0;
   int failures = 0;

   // reference model state
   int my [N];
   bit ma [N];
   int lx [N];
   logic [ADDR_W:0] exp_q [$];

   enemy_lane_engine #(
      .N(N), .SPR_W(SPR_W), .SPR_H(SPR_H), .ADDR_W(ADDR_W), .SPEED(SPEED),
      .Y_LIMIT(Y_LIMIT), .Y_PARK(Y_PARK), .H_ACT(H_ACT), .V_ACT(V_ACT)
   ) dut (
      .clk(clk), .reset(rst_n), .tick(tick), .spawn(spawn), .lane_x(lane_x),
      .freeze(freeze), .hcount(hcount), .vcount(vcount), .pos_y(pos_y),
      .active(active), .rom_addr(rom_addr), .rom_data(rom_data),
      .pixel(pixel), .pixel_valid(pixel_valid)
   );

   // clock
   always #5 clk = ~clk;

   // asynchronous sprite ROM stand-in
   function automatic logic [2:0] rom_fn(input logic [ADDR_W-1:0] a);
      return a[2:0] ^ a[5:3] ^ a[8:6] ^ a[11:9];
   endfunction
   assign rom_data = rom_fn(rom_addr);

   // ---------------- reference model ----------------
   function automatic void model_reset();
      for (int i = 0; i < N; i++) begin
         my[i] = Y_PARK;
         ma[i] = 1'b0;
      end
   endfunction

   function automatic void model_tick(input logic [N-1:0] sp, input logic fz);
      if (fz) return;
      for (int i = 0; i < N; i++) begin
         if (sp[i]) begin
            my[i] = 0;
            ma[i] = 1'b1;
         end else if (ma[i]) begin
            if (my[i] + SPEED < Y_LIMIT) my[i] = my[i] + SPEED;
            else begin
               my[i] = Y_PARK;
               ma[i] = 1'b0;
            end
         end
      end
   endfunction

   function automatic logic [N*10-1:0] model_pos();
      logic [N*10-1:0] r;
      for (int i = 0; i < N; i++) r[10*i +: 10] = 10'(my[i]);
      return r;
   endfunction

   function automatic logic [N-1:0] model_act();
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) r[i] = ma[i];
      return r;
   endfunction

   // {hit, address} for a beam position, from the lane rectangles
   function automatic logic [ADDR_W:0] ref_pixel(input int h, input int v);
      if (h >= H_ACT || v >= V_ACT) return '0;
      for (int i = 0; i < N; i++)
         if (v >= my[i] && v < my[i] + SPR_H && h >= lx[i] && h < lx[i] + SPR_W)
            return {1'b1, ADDR_W'((v - my[i]) * SPR_W + (h - lx[i]))};
      return '0;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic set_x(input int i, input int val);
      lx[i] = val;
      lane_x[10*i +: 10] = 10'(val);
   endtask

   task automatic set_beam(input int h, input int v);
      hcount = 10'(h);
      vcount = 10'(v);
   endtask

   task automatic drive_tick(input logic [N-1:0] sp, input logic fz);
      tick = 1'b1;
      spawn = sp;
      freeze = fz;
      model_tick(sp, fz);
      @(posedge clk); #1;
      tick = 1'b0;
      spawn = '0;
      freeze = 1'b0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      set_x(0, 0);
      set_beam(5, 5);
      drive_tick(4'b0101, 1'b0);
      drive_tick(4'b0000, 1'b0);
      @(posedge clk); #1;
      checks++;
      if (pixel_valid !== 1'b1) begin
         failures++;
         $display("FAIL reset_precond_valid: got %0b expected 1", pixel_valid);
      end
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (pos_y !== model_pos() || active !== 4'b0000) begin
         failures++;
         $display("FAIL reset_async_lanes: pos_y %h active %b expected pos_y %h active 0000", pos_y, active, model_pos());
      end
      checks++;
      if (pixel_valid !== 1'b0 || rom_addr !== '0 || pixel !== 3'd0) begin
         failures++;
         $display("FAIL reset_async_pixel: valid %0b addr %0d pixel %0d expected 0 0 0", pixel_valid, rom_addr, pixel);
      end
      @(posedge clk); #1;
      checks++;
      if (pos_y !== {4{10'd620}} || active !== 4'b0000 || pixel_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_held: pos_y %h active %b valid %0b expected all 620, 0, 0", pos_y, active, pixel_valid);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (pixel_valid !== 1'b0 || pos_y !== {4{10'd620}} || active !== 4'b0000) begin
         failures++;
         $display("FAIL reset_release: valid %0b pos_y %h active %b expected 0, all 620, 0", pixel_valid, pos_y, active);
      end
      set_beam(1000, 1000);
   endtask

   task automatic test_single_fall();
      drive_tick(4'b0001, 1'b0);
      checks++;
      if (pos_y[9:0] !== 10'd0 || active[0] !== 1'b1) begin
         failures++;
         $display("FAIL fall_spawn: y %0d active %0b expected 0 1", pos_y[9:0], active[0]);
      end
      for (int k = 1; k <= 600; k++) begin
         drive_tick(4'b0000, 1'b0);
         checks++;
         if (pos_y !== model_pos() || active !== model_act() || pos_y[9:0] !== 10'(k)) begin
            failures++;
            $display("FAIL fall_step%0d: pos_y %h active %b expected %h %b", k, pos_y, active, model_pos(), model_act());
         end
      end
      drive_tick(4'b0000, 1'b0);
      checks++;
      if (pos_y[9:0] !== 10'd620 || active[0] !== 1'b0) begin
         failures++;
         $display("FAIL fall_park: y %0d active %0b expected 620 0", pos_y[9:0], active[0]);
      end
   endtask

   task automatic test_freeze();
      logic [N*10-1:0] held;
      drive_tick(4'b1001, 1'b0);
      repeat (10) drive_tick(4'b0000, 1'b0);
      held = model_pos();
      for (int k = 0; k < 5; k++) begin
         drive_tick((k == 2) ? 4'b0010 : 4'b0000, 1'b1);
         checks++;
         if (pos_y !== held || active[1] !== 1'b0) begin
            failures++;
            $display("FAIL freeze_hold%0d: pos_y %h active %b expected %h lane1 0", k, pos_y, active, held);
         end
      end
      drive_tick(4'b0000, 1'b0);
      checks++;
      if (pos_y !== model_pos() || active !== model_act() || pos_y[9:0] !== 10'd11) begin
         failures++;
         $display("FAIL freeze_resume: pos_y %h active %b expected %h %b", pos_y, active, model_pos(), model_act());
      end
   endtask

   task automatic test_respawn();
      drive_tick(4'b0100, 1'b0);
      repeat (300) drive_tick(4'b0000, 1'b0);
      checks++;
      if (pos_y[29:20] !== 10'd300 || active[2] !== 1'b1) begin
         failures++;
         $display("FAIL respawn_pre: y %0d active %0b expected 300 1", pos_y[29:20], active[2]);
      end
      drive_tick(4'b0100, 1'b0);
      checks++;
      if (pos_y[29:20] !== 10'd0 || active[2] !== 1'b1 || pos_y !== model_pos()) begin
         failures++;
         $display("FAIL respawn: y %0d active %0b expected 0 1", pos_y[29:20], active[2]);
      end
   endtask

   task automatic test_pixel_directed();
      apply_reset();
      set_x(0, 100);
      drive_tick(4'b0001, 1'b0);
      repeat (50) drive_tick(4'b0000, 1'b0);
      set_beam(105, 52);
      @(posedge clk); #1;
      checks++;
      if (rom_addr !== 14'd165) begin
         failures++;
         $display("FAIL pix_addr: got %0d expected 165", rom_addr);
      end
      @(posedge clk); #1;
      checks++;
      if (pixel !== rom_fn(14'd165) || pixel_valid !== 1'b1) begin
         failures++;
         $display("FAIL pix_data: pixel %0d valid %0b expected %0d 1", pixel, pixel_valid, rom_fn(14'd165));
      end
      set_beam(1000, 1000);
   endtask

   task automatic test_overlap();
      apply_reset();
      set_x(0, 400); set_x(1, 150); set_x(2, 600); set_x(3, 180);
      drive_tick(4'b1000, 1'b0);
      repeat (30) drive_tick(4'b0000, 1'b0);
      drive_tick(4'b0010, 1'b0);
      repeat (100) drive_tick(4'b0000, 1'b0);
      set_beam(200, 200);
      @(posedge clk); #1;
      checks++;
      if (rom_addr !== 14'd8050) begin
         failures++;
         $display("FAIL overlap_addr: got %0d expected 8050", rom_addr);
      end
      @(posedge clk); #1;
      checks++;
      if (pixel_valid !== 1'b1 || pixel !== rom_fn(14'd8050)) begin
         failures++;
         $display("FAIL overlap_pixel: pixel %0d valid %0b expected %0d 1", pixel, pixel_valid, rom_fn(14'd8050));
      end
      drive_tick(4'b0100, 1'b0);
      repeat (5) drive_tick(4'b0000, 1'b0);
      set_beam(640, 10);
      @(posedge clk); #1;
      checks++;
      if (rom_addr !== 14'd0) begin
         failures++;
         $display("FAIL hedge_addr: got %0d expected 0", rom_addr);
      end
      set_beam(639, 10);
      @(posedge clk); #1;
      checks++;
      if (pixel_valid !== 1'b0 || rom_addr !== 14'd439) begin
         failures++;
         $display("FAIL hedge_edge: valid %0b addr %0d expected 0 439", pixel_valid, rom_addr);
      end
      @(posedge clk); #1;
      checks++;
      if (pixel_valid !== 1'b1) begin
         failures++;
         $display("FAIL hedge_inside_valid: got %0b expected 1", pixel_valid);
      end
      set_beam(1000, 1000);
   endtask

   // randomized stream: random ticks/spawns/freezes coinciding with beam samples
   task automatic test_random();
      logic [ADDR_W:0] e_new, e_old;
      logic [N-1:0] sp;
      logic tk, fz;
      int h, v;
      apply_reset();
      for (int i = 0; i < N; i++) set_x(i, $urandom_range(0, 620));
      exp_q.delete();
      for (int c = 0; c < 3000; c++) begin
         if (c % 256 == 255) set_x($urandom_range(0, N-1), $urandom_range(0, 620));
         tk = ($urandom_range(0, 1) == 1);
         sp = '0;
         for (int i = 0; i < N; i++) sp[i] = ($urandom_range(0, 199) == 0);
         fz = ($urandom_range(0, 9) == 0);
         h = $urandom_range(0, 760);
         v = $urandom_range(0, 520);
         set_beam(h, v);
         tick = tk;
         spawn = sp;
         freeze = fz;
         exp_q.push_back(ref_pixel(h, v));
         if (tk) model_tick(sp, fz);
         @(posedge clk); #1;
         tick = 1'b0;
         spawn = '0;
         freeze = 1'b0;
         checks++;
         if (pos_y !== model_pos() || active !== model_act()) begin
            failures++;
            $display("FAIL rand_lanes c%0d: pos_y %h active %b expected %h %b", c, pos_y, active, model_pos(), model_act());
         end
         e_new = exp_q[$];
         checks++;
         if (rom_addr !== e_new[ADDR_W-1:0]) begin
            failures++;
            $display("FAIL rand_addr c%0d: got %0d expected %0d", c, rom_addr, e_new[ADDR_W-1:0]);
         end
         if (exp_q.size() == 2) begin
            e_old = exp_q.pop_front();
            checks++;
            if (pixel_valid !== e_old[ADDR_W] || pixel !== rom_fn(e_old[ADDR_W-1:0])) begin
               failures++;
               $display("FAIL rand_pixel c%0d: pixel %0d valid %0b expected %0d %0b", c, pixel, pixel_valid, rom_fn(e_old[ADDR_W-1:0]), e_old[ADDR_W]);
            end
         end
      end
      set_beam(1000, 1000);
   endtask

   // sequence and final report
   initial begin
      model_reset();
      for (int i = 0; i < N; i++) set_x(i, 0);
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_single_fall();
      test_freeze();
      test_respawn();
      test_pixel_directed();
      test_overlap();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/enemy_lane_engine.md
# enemy_lane_engine

Parametrised multi-lane enemy sprite engine for the VGA racing game. It tracks N independently spawned enemy cars falling down the screen, one per lane, with a shared freeze on collision. Each lane parks off-screen when it passes the bottom limit. A registered pixel path generates the sprite ROM address for the lane covering the current beam position and returns its 3-bit colour, so the top-level mixer sees one priority-resolved enemy layer.

## Interface
Parameters:
- N, 4: number of enemy lanes
- SPR_W, 80: sprite width in pixels
- SPR_H, 121: sprite height in lines
- ADDR_W, 14: ROM address width; requires SPR_W*SPR_H <= 2^ADDR_W
- SPEED, 1: pixels moved per tick
- Y_LIMIT, 601: a lane parks when its next y would be >= Y_LIMIT
- Y_PARK, 620: parked y value
- H_ACT, 640 / V_ACT, 480: active display size

Ports:
- clk  in  1  pixel clock, the only clock
- reset  in  1  asynchronous, active-low; 0 resets all state
- tick  in  1  one-cycle game-logic strobe, one per frame, asserted in vblank
- spawn  in  N  per-lane spawn request, sampled only on tick
- lane_x  in  N*10  packed lane x offsets; lane i uses bits [10i+9:10i]
- freeze  in  1  collision freeze; halts all lane motion and spawning
- hcount  in  10  beam column
- vcount  in  10  beam line
- pos_y  out  N*10  packed lane y positions, registered
- active  out  N  lane i is falling
- rom_addr  out  ADDR_W  sprite ROM address, registered
- rom_data  in  3  colour from the asynchronous sprite ROM at rom_addr
- pixel  out  3  enemy colour, registered
- pixel_valid  out  1  pixel belongs to an enemy sprite

## Operation
- Each lane has two states: PARKED (y=Y_PARK, active=0) and FALLING (active=1).
- On tick with freeze=0, for each lane:
  - spawn[i]=1 in either state: y<=0, FALLING. A spawn while falling restarts the lane.
  - FALLING without spawn: if y+SPEED < Y_LIMIT, then y<=y+SPEED; otherwise y<=Y_PARK and the lane goes PARKED.
  - PARKED without spawn: the lane holds.
- While tick=0, or on tick with freeze=1, every lane holds. Spawns arriving during freeze are dropped, not queued.
- Lane i hits when vcount<V_ACT, hcount<H_ACT, y<=vcount<y+SPR_H and x<=hcount<x+SPR_W. All comparisons use 11-bit sums so there is no wrap near 1023.
- When several lanes hit, the lowest index wins.
- Address of the winning lane = (vcount-y)*SPR_W + (hcount-x), truncated to ADDR_W. The address is computed, not counted, so there is no cross-frame drift.
- With no hit, rom_addr=0 and pixel_valid=0. Colour 3'b000 inside a sprite is still reported with pixel_valid=1; transparency is decided by the mixer.

## Timing
- Reset values: pos_y = Y_PARK in every lane, active=0, rom_addr=0, pixel=0, pixel_valid=0. Reset mid-frame takes effect immediately because it is asynchronous.
- Lane update is one clock: pos_y/active change on the clk edge where tick=1.
- Pixel pipeline, with beam position sampled at edge n:
  - edge n+1: rom_addr and the internal hit flag are registered.
  - edge n+2: pixel<=rom_data and pixel_valid<=hit.
  - Total latency is 2 clocks. The caller delays sync signals to match.
- When tick and a beam position in the pipeline coincide, the pixel path uses pre-tick y for stage 1 of that sample.
- Boundaries:
  - With SPEED=1, lane y goes 599->600; at y=600 the next tick parks it, so y=601 never appears.
  - Once parked (y=Y_PARK), vcount never reaches the sprite, so parked lanes never hit.

## Test plan
- Reset: drive reset=0 mid-run -> pos_y lanes all 620, active=0, pixel_valid=0 while reset is low and on the first clock after release.
- Single lane fall: spawn[0] on tick, then 600 more ticks -> lane 0 y goes 0,1,...,600; the next tick parks it (y=620, active=0).
- Freeze: freeze=1 over 5 ticks, with spawn[1] pulsed during the freeze -> all y unchanged and lane 1 stays parked; motion resumes on the first tick after freeze=0.
- Respawn mid-fall: lane 2 at y=300, spawn[2] on tick -> y=0, active stays 1.
- Pixel path: lane 0 at x=100, y=50, beam (hcount,vcount)=(105,52) at edge n -> rom_addr=2*80+5=165 at n+1; pixel equals rom_data, pixel_valid=1 at n+2.
- Overlap priority: lanes 1 and 3 both cover (200,200) -> address from lane 1. Beam at (640,10) -> pixel_valid=0, rom_addr=0.
